// File: rtl/axi_sram_slave_p.sv
// AXI SRAM slave, one burst at a time, round-robin AR/AW; first R beat 1 cycle after AR handshake.
// Backpressure: R/B outputs held stable while RREADY/BREADY low; WREADY high throughout a write burst.
module axi_sram_slave_p #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int DEPTH  = 16384
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     ARID,
  input  logic [31:0]         ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SH     = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q;
  logic [3:0]          len_q;
  logic [1:0]          burst_q;
  logic [31:0]         word_q;
  logic [3:0]          beat_q;
  logic                ill_q;
  logic                err_q;
  logic                prio_wr_q;
  logic [1:0]          rresp_q;
  logic                rd_zero_q;
  logic [DATA_W-1:0]   mem_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ar_hs, aw_hs, r_hs, w_hs, b_hs, contested, last_beat;
  logic                rd_load, rd_oob, rd_bad, wr_oob, wr_en;
  logic [31:0]         rd_word;

  function automatic logic burst_bad(input logic [1:0] b, input logic [3:0] l);
    return (b == 2'b11) ||
           ((b == 2'b10) && !(l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15));
  endfunction

  // Illegal bursts fall through to INCR addressing.
  function automatic logic [31:0] next_word(input logic [31:0] cur, input logic [1:0] b,
                                            input logic [3:0] l);
    logic [31:0] mask;
    mask = {28'd0, l};
    if (b == 2'b00)
      return cur;
    else if (b == 2'b10 && !burst_bad(b, l))
      return (cur & ~mask) | ((cur + 32'd1) & mask);
    else
      return cur + 32'd1;
  endfunction

  always_comb begin
    ARREADY   = 1'b0;
    AWREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    RID       = id_q;
    BID       = id_q;
    RRESP     = rresp_q;
    RDATA     = rd_zero_q ? '0 : mem_q;
    BRESP     = (state_q == S_WRESP) ? {err_q, 1'b0} : 2'b00;
    state_d   = state_q;
    last_beat = (beat_q == len_q);
    contested = ARVALID && AWVALID;

    if (!ARESET) begin
      ARREADY = (state_q == S_IDLE) && ARVALID && (!AWVALID || !prio_wr_q);
      AWREADY = (state_q == S_IDLE) && AWVALID && (!ARVALID || prio_wr_q);
      RVALID  = (state_q == S_RD);
      RLAST   = (state_q == S_RD) && last_beat;
      WREADY  = (state_q == S_WR);
      BVALID  = (state_q == S_WRESP);
    end

    ar_hs = ARVALID && ARREADY;
    aw_hs = AWVALID && AWREADY;
    r_hs  = RVALID && RREADY;
    w_hs  = WVALID && WREADY;
    b_hs  = BVALID && BREADY;

    // Beat 0 is fetched on the AR edge itself so RVALID can rise the next cycle.
    rd_load = ar_hs || (r_hs && !last_beat);
    rd_word = ar_hs ? (ARADDR >> SH) : next_word(word_q, burst_q, len_q);
    rd_bad  = ar_hs ? burst_bad(ARBURST, ARLEN) : ill_q;
    rd_oob  = (rd_word >= 32'(DEPTH));
    wr_oob  = (word_q >= 32'(DEPTH));
    wr_en   = w_hs && !wr_oob;

    case (state_q)
      S_IDLE:  if (ar_hs) state_d = S_RD; else if (aw_hs) state_d = S_WR;
      S_RD:    if (r_hs && last_beat) state_d = S_IDLE;
      S_WR:    if (w_hs && last_beat) state_d = S_WRESP;
      S_WRESP: if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (rd_load)
      mem_q <= mem[rd_word[IDX_W-1:0]];
    if (wr_en)
      for (int b = 0; b < STRB_W; b++)
        if (WSTRB[b])
          mem[word_q[IDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      word_q    <= '0;
      beat_q    <= '0;
      ill_q     <= 1'b0;
      err_q     <= 1'b0;
      prio_wr_q <= 1'b1;
      rresp_q   <= 2'b00;
      rd_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ar_hs || aw_hs) begin
        id_q    <= ar_hs ? ARID : AWID;
        len_q   <= ar_hs ? ARLEN : AWLEN;
        burst_q <= ar_hs ? ARBURST : AWBURST;
        word_q  <= ar_hs ? (ARADDR >> SH) : (AWADDR >> SH);
        beat_q  <= '0;
        // Priority only moves when both channels competed; the winner yields next time.
        if (contested)
          prio_wr_q <= ar_hs;
      end
      if (ar_hs)
        ill_q <= burst_bad(ARBURST, ARLEN);
      if (aw_hs) begin
        ill_q <= burst_bad(AWBURST, AWLEN);
        err_q <= burst_bad(AWBURST, AWLEN);
      end
      if (rd_load) begin
        rd_zero_q <= rd_oob;
        rresp_q   <= (rd_oob || rd_bad) ? 2'b10 : 2'b00;
      end
      if (r_hs && !last_beat) begin
        word_q <= rd_word;
        beat_q <= beat_q + 4'd1;
      end
      if (w_hs) begin
        word_q <= next_word(word_q, burst_q, len_q);
        beat_q <= beat_q + 4'd1;
        if (wr_oob || (WLAST != last_beat))
          err_q <= 1'b1;
      end
    end
  end

endmodule
